// File: rtl/tt_dff_pkg.sv
// Shared pin-bit indices and reset constants for the two-stage D flip-flop slot.
package tt_dff_pkg;

    localparam int unsigned WE   = 0;
    localparam int unsigned SEL  = 1;
    localparam int unsigned CLR  = 2;
    localparam int unsigned HOLD = 3;

    localparam int unsigned DIFF = 4;
    localparam int unsigned PAR  = 5;
    localparam int unsigned ZERO = 6;
    localparam int unsigned TOG  = 7;

    localparam logic [7:0] UIO_OE_MASK = 8'hF0;
    localparam logic [7:0] Q_RESET     = 8'h00;

    typedef struct packed {
        logic hold;
        logic clr;
        logic sel;
        logic we;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [7:0] uio);
        ctrl_t c;
        c.we   = uio[WE];
        c.sel  = uio[SEL];
        c.clr  = uio[CLR];
        c.hold = uio[HOLD];
        return c;
    endfunction

endpackage

// File: rtl/dff_reg8.sv
// 8-bit register: async active-high reset, synchronous clear over load enable.
// Latency 1 cycle; no backpressure, holds when load is low.
module dff_reg8
    import tt_dff_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] d,
    output logic [7:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= Q_RESET;
        end else if (clr) begin
            q <= Q_RESET;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/tt_um_d_flip_flop_2.sv
// Two-stage 8-bit D flip-flop pipeline; optional Q2 parity flag under DFF_PARITY_EN.
// Latency: 1 edge to Q1 (sel=0), 2 edges to Q2 (sel=1); hold/ena=0 freeze without loss.
module tt_um_d_flip_flop_2
    import tt_dff_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    ctrl_t      ctrl;
    logic       clr_go;
    logic       advance;
    logic [7:0] q1;
    logic [7:0] q2;
    logic       tog;
    logic       par;
    logic       unused_uio;

    assign ctrl       = decode_ctrl(uio_in);
    assign unused_uio = &{1'b0, uio_in[7:4]};

    // clr beats hold beats normal advance; ena gates everything, clr included.
    assign clr_go  = ena & ctrl.clr;
    assign advance = ena & ~ctrl.clr & ~ctrl.hold;

    dff_reg8 u_q1 (
        .clk  (clk),
        .rst  (rst_n),
        .clr  (clr_go),
        .load (advance & ctrl.we),
        .d    (ui_in),
        .q    (q1)
    );

    dff_reg8 u_q2 (
        .clk  (clk),
        .rst  (rst_n),
        .clr  (clr_go),
        .load (advance),
        .d    (q1),
        .q    (q2)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tog <= 1'b0;
        end else if (clr_go) begin
            tog <= 1'b0;
        end else if (advance & ctrl.we) begin
            tog <= ~tog;
        end
    end

`ifdef DFF_PARITY_EN
    assign par = ^q2;
`else
    assign par = 1'b0;
`endif

    always_comb begin
        uio_out       = 8'h00;
        uio_out[DIFF] = (q1 != q2);
        uio_out[PAR]  = par;
        uio_out[ZERO] = (q1 == Q_RESET);
        uio_out[TOG]  = tog;
    end

    assign uo_out = ctrl.sel ? q2 : q1;
    assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_d_flip_flop_2.sv
// Bench for the two-stage D flip-flop slot: directed vector table, hand corner cases, random vs. model.
module tb_tt_um_d_flip_flop_2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_vec = 0;
    int n_bad = 0;

`ifdef DFF_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    tt_um_d_flip_flop_2 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ena;
        logic [7:0] ui;
        logic [7:0] ctl;
        logic [7:0] uo;
        logic [7:0] uio;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Status byte as the pins should show it; the parity column is written as if enabled.
    function automatic logic [7:0] pmask(input logic [7:0] v);
        return PAR_ON ? v : (v & 8'hDF);
    endfunction

    // Reference model: the pipeline as a two-slot array plus a capture-count parity bit.
    logic [7:0] m_stage [2];
    logic       m_tog;

    task automatic model_edge(input logic r, input logic e, input logic [7:0] d, input logic [7:0] c);
        if (r) begin
            m_stage[0] = 8'h00; m_stage[1] = 8'h00; m_tog = 1'b0;
        end else if (e) begin
            if (c[2]) begin
                m_stage[0] = 8'h00; m_stage[1] = 8'h00; m_tog = 1'b0;
            end else if (!c[3]) begin
                m_stage[1] = m_stage[0];
                if (c[0]) begin
                    m_stage[0] = d;
                    m_tog = !m_tog;
                end
            end
        end
    endtask

    function automatic logic [7:0] model_uio();
        logic [7:0] s;
        s = 8'h00;
        s[4] = (m_stage[0] != m_stage[1]);
        s[5] = PAR_ON ? (($countones(m_stage[1]) % 2) == 1) : 1'b0;
        s[6] = (m_stage[0] == 8'h00);
        s[7] = m_tog;
        return s;
    endfunction

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #1;
        check("reset_uo", uo_out, 8'h00);
        check("reset_uio", uio_out, 8'h40);
        check("reset_oe", uio_oe, 8'hF0);
        @(posedge clk);

        //           rst   ena   ui     ctl    uo     uio
        vecs.push_back('{1'b0, 1'b1, 8'h3C, 8'h01, 8'h3C, 8'h90});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h02, 8'h3C, 8'h80});
        vecs.push_back('{1'b1, 1'b1, 8'hFF, 8'h01, 8'h00, 8'h40});
        vecs.push_back('{1'b0, 1'b1, 8'h01, 8'h01, 8'h01, 8'h90});
        vecs.push_back('{1'b0, 1'b1, 8'h02, 8'h03, 8'h01, 8'h30});
        vecs.push_back('{1'b0, 1'b1, 8'h03, 8'h03, 8'h02, 8'hB0});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 8'hF2, 8'h03, 8'h80});
        vecs.push_back('{1'b0, 1'b1, 8'h55, 8'h01, 8'h55, 8'h10});
        for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 1'b1, 8'hFF, 8'h09, 8'h55, 8'h10});
        for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 1'b0, 8'hFF, 8'h01, 8'h55, 8'h10});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h02, 8'h55, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 8'h07, 8'h01, 8'h07, 8'h90});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h02, 8'h07, 8'hA0});
        vecs.push_back('{1'b0, 1'b0, 8'hAA, 8'h0F, 8'h07, 8'hA0});
        vecs.push_back('{1'b0, 1'b1, 8'hAA, 8'h0D, 8'h00, 8'h40});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h02, 8'h00, 8'h40});

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n  = vecs[i].rst;
            ena    = vecs[i].ena;
            ui_in  = vecs[i].ui;
            uio_in = vecs[i].ctl;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_uo", i), uo_out, vecs[i].uo);
            check($sformatf("vec%0d_uio", i), uio_out, pmask(vecs[i].uio));
        end

        // sel switches uo_out combinationally, before any edge.
        @(negedge clk);
        ui_in = 8'hA5; uio_in = 8'h01;
        @(posedge clk);
        #1;
        check("a5_q1", uo_out, 8'hA5);
        @(negedge clk);
        uio_in = 8'h02;
        #1;
        check("sel_comb_q2", uo_out, 8'h00);
        uio_in = 8'h00;
        #1;
        check("sel_comb_q1", uo_out, 8'hA5);

        // Async reset mid-operation with Q1=A5: clears without an edge.
        rst_n = 1'b1;
        #1;
        check("arst_uo", uo_out, 8'h00);
        check("arst_uio", uio_out, 8'h40);
        check("arst_oe", uio_oe, 8'hF0);
        @(negedge clk);
        rst_n = 1'b0;

        m_stage[0] = 8'h00; m_stage[1] = 8'h00; m_tog = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic [7:0] c;
            @(negedge clk);
            c = 8'($urandom);
            if ($urandom_range(0, 7) != 0) c[2] = 1'b0;
            if ($urandom_range(0, 3) != 0) c[3] = 1'b0;
            rst_n  = ($urandom_range(0, 31) == 0);
            ena    = ($urandom_range(0, 3) != 0);
            ui_in  = 8'($urandom);
            uio_in = c;
            model_edge(rst_n, ena, ui_in, c);
            @(posedge clk);
            #1;
            check("rnd_uo", uo_out, c[1] ? m_stage[1] : m_stage[0]);
            check("rnd_uio", uio_out, model_uio());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
